four_bit_sub_serial: RTL and testbench
======================================

# four_bit_sub_serial

Bit-serial 4-bit unsigned subtractor with a start/done handshake, the inverse-direction companion of the combinational 4-bit adder in the ALU datapath. It computes A_in − B_in one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It returns a 5-bit result in the same format as the adder's sum: difference in bits [3:0], borrow-out in bit [4]. The ALU uses it for the SUB operation and the compare operation.

## Interface
- No parameters; operand width is fixed at 4 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_in  input  1  request; sampled only when not busy
- A_in  input  4  minuend, captured on the accepting edge
- B_in  input  4  subtrahend, captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; diff is valid from this cycle onward
- diff  output  5  [3:0] = (A−B) mod 16; [4] = borrow (1 iff A < B unsigned)
- ovf  output  1  signed overflow; present only with SUB_OVF_EN

## Operation
- FSM states:
  - IDLE: reset state.
  - SHIFT: four cycles, one result bit per cycle, 2-bit counter 0..3.
  - DONE: one cycle.
- IDLE or DONE with start_in=1 on an edge:
  - Latch A_in and B_in into shift registers.
  - Clear the borrow flop.
  - Clear the counter.
  - Go to SHIFT.
- IDLE with start_in=0: stay in IDLE.
- DONE with start_in=0: go to IDLE.
- Each SHIFT edge:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result register MSB-side, so bit i lands at position i after 4 shifts.
  - Shift the operand registers right.
- On the SHIFT edge with counter=3:
  - diff[3:0] ← assembled result.
  - diff[4] ← final borrow.
  - Go to DONE.
- start_in is ignored while in SHIFT. The operation is not restarted and the operands are not re-latched.
- diff holds the last completed result; it changes only on a SHIFT→DONE edge or on reset.
- A_in and B_in may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, diff=5'b00000, ovf=0. State is IDLE, counter 0, borrow 0.
- Reset asserted mid-operation aborts immediately and asynchronously. No done pulse is issued.
- busy is high in SHIFT only; it is low in IDLE and DONE.
- done is high in DONE only, for exactly one cycle per operation.
- Latency: start accepted at edge E0. SHIFT occupies E1..E4, with diff registered at E4. done is high from E4 to E5.
- Throughput: start asserted during the done cycle is accepted at E5, giving one result every 5 cycles.
- Holding start_in high continuously yields back-to-back operations.

## Configuration
- SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf is registered on the same edge as diff: ovf = (A[3] != B[3]) && (diff[3] != A[3]), using the latched operand sign bits.
  - ovf holds with diff and resets to 0.
- SUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then A=9, B=3, start pulse at E0 → busy high E0..E4. At E4, diff=5'b00110 and done=1 for one cycle. Then IDLE.
- A=3, B=9 → diff=5'b11010 (10 with borrow=1). A=15, B=15 → 5'b00000. A=0, B=15 → 5'b10001.
- start_in held high, operands 9−3 then 8−1 → done pulses at E4 and E9. diff=6 then 7.
- A=5, B=2, then start_in re-pulsed at E2 with A=1, B=1 → the second request is ignored and the result is diff=5'b00011.
- Start 9−3, assert rst at E2 → busy=0 and diff=0 immediately. No done pulse. After release, a new 4−4 request gives diff=0 at E4 after its start.
- With SUB_OVF_EN:
  - 7 − 8 (signed 7 − (−8)) → diff=5'b11111, ovf=1.
  - 6 − 2 → ovf=0.
  - Without the macro, the bench compiles with no ovf port.

Source files
------------

// File: rtl/four_bit_sub_serial.sv
// Bit-serial 4-bit unsigned subtractor (A - B, LSB first) with a start/done handshake.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module four_bit_sub_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  output logic       busy,
  output logic       done,
  output logic [4:0] diff
`ifdef SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] res_q;
  logic       br_q;
  logic [1:0] cnt_q;
`ifdef SUB_OVF_EN
  logic       a_sign_q;
  logic       b_sign_q;
`endif

  logic       d_bit_d;
  logic       br_d;

  // Full-subtractor cell on the current LSBs and the registered borrow
  always_comb begin
    d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      res_q    <= 4'd0;
      br_q     <= 1'b0;
      cnt_q    <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= 5'd0;
`ifdef SUB_OVF_EN
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start_in) begin
            a_q      <= A_in;
            b_q      <= B_in;
            br_q     <= 1'b0;
            cnt_q    <= 2'd0;
            busy     <= 1'b1;
            state_q  <= SHIFT;
`ifdef SUB_OVF_EN
            a_sign_q <= A_in[3];
            b_sign_q <= B_in[3];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= {1'b0, a_q[3:1]};
          b_q   <= {1'b0, b_q[3:1]};
          br_q  <= br_d;
          res_q <= {d_bit_d, res_q[3:1]};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Last bit goes straight into diff; res_q only holds bits 0..2 here
            diff    <= {br_d, d_bit_d, res_q[3:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
`ifdef SUB_OVF_EN
            ovf     <= (a_sign_q != b_sign_q) && (d_bit_d != a_sign_q);
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_sub_serial.sv
// Directed self-checking bench for four_bit_sub_serial (define SUB_OVF_EN to cover ovf).
module tb_four_bit_sub_serial;

  logic       clk;
  logic       rst;
  logic       start_in;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       busy;
  logic       done;
  logic [4:0] diff;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  int n_checks;
  int n_fail;

  four_bit_sub_serial dut (
    .clk      (clk),
    .rst      (rst),
    .start_in (start_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .busy     (busy),
    .done     (done),
    .diff     (diff)
`ifdef SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; start is sampled on the following posedge (E0)
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] exp_diff, input logic exp_ovf, input string nm);
    A_in = a; B_in = b; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/done during shift %0d: busy=%b done=%b want busy=1 done=0", nm, i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== exp_diff) begin
      n_fail++;
      $display("FAIL %s result: done=%b busy=%b diff=%b want done=1 busy=0 diff=%b", nm, done, busy, diff, exp_diff);
    end
`ifdef SUB_OVF_EN
    n_checks++;
    if (ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b want %b", nm, ovf, exp_ovf);
    end
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x ovf expectation for %s", nm);
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_diff) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b diff=%b want done=0 busy=0 diff=%b", nm, done, busy, diff, exp_diff);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0; A_in = 4'd0; B_in = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b diff=%b want 0 0 00000", busy, done, diff);
    end
`ifdef SUB_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(4'd9,  4'd3,  5'b00110, 1'b1, "sub_9_3");
    do_op(4'd3,  4'd9,  5'b11010, 1'b1, "sub_3_9");
    do_op(4'd15, 4'd15, 5'b00000, 1'b0, "sub_15_15");
    do_op(4'd0,  4'd15, 5'b10001, 1'b0, "sub_0_15");
    do_op(4'd7,  4'd8,  5'b11111, 1'b1, "sub_7_8");
    do_op(4'd6,  4'd2,  5'b00100, 1'b0, "sub_6_2");
    // diff must hold while idle
    repeat (3) @(negedge clk);
    n_checks++;
    if (diff !== 5'b00100 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: diff=%b done=%b want 00100 0", diff, done);
    end
  endtask

  task automatic test_back_to_back();
    A_in = 4'd9; B_in = 4'd3; start_in = 1'b1;
    @(negedge clk);                    // after E0
    A_in = 4'd8; B_in = 4'd1;
    repeat (4) @(negedge clk);         // after E4
    n_checks++;
    if (done !== 1'b1 || diff !== 5'b00110) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b diff=%b want 1 00110", done, diff);
    end
    @(negedge clk);                    // after E5
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: done=%b busy=%b want 0 1", done, busy);
    end
    repeat (4) @(negedge clk);         // after E9
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 5'b00111) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b busy=%b diff=%b want 1 0 00111", done, busy, diff);
    end
`ifdef SUB_OVF_EN
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ovf: got %b want 1", ovf);
    end
`endif
    start_in = 1'b0;
    @(negedge clk);                    // after E10
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_ignore_restart();
    A_in = 4'd5; B_in = 4'd2; start_in = 1'b1;
    @(negedge clk);                    // after E0
    start_in = 1'b0;
    @(negedge clk);                    // after E1
    A_in = 4'd1; B_in = 4'd1; start_in = 1'b1;
    @(negedge clk);                    // after E2
    start_in = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_busy: got %b want 1", busy);
    end
    repeat (2) @(negedge clk);         // after E4
    n_checks++;
    if (done !== 1'b1 || diff !== 5'b00011) begin
      n_fail++;
      $display("FAIL restart_ignored: done=%b diff=%b want 1 00011", done, diff);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    A_in = 4'd9; B_in = 4'd3; start_in = 1'b1;
    @(negedge clk);                    // after E0
    start_in = 1'b0;
    @(negedge clk);                    // after E1
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || diff !== 5'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: busy=%b diff=%b done=%b want 0 00000 0", busy, diff, done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: activity seen after abort=%b want 0", saw_done);
    end
    do_op(4'd4, 4'd4, 5'b00000, 1'b0, "sub_4_4_after_rst");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_restart();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
